// File: rtl/p_pkg.sv
// Shared PRESENT-80 definitions: widths, 4-bit S-box table and lookup,
// and the 64-bit pLayer bit permutation.
package p_pkg;

   localparam int STATE_W = 64;
   localparam int KEY_W   = 80;
   localparam int RC_W    = 5;

   localparam logic [3:0] SBOX_T [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX_T[x];
   endfunction

   // Bit b of nibble n lands at 16*b + n; this is (16*j) mod 63 with 63 fixed.
   function automatic logic [STATE_W-1:0] player(
      input logic [STATE_W-1:0] x
   );
      logic [STATE_W-1:0] y;
      y = '0;
      for (int n = 0; n < 16; n++) begin
         for (int b = 0; b < 4; b++) begin
            y[16*b+n] = x[4*n+b];
         end
      end
      return y;
   endfunction

endpackage

// File: rtl/p_sbox4.sv
// Combinational PRESENT 4-bit S-box.
// Ports: x (4-bit in), y (4-bit substituted out).
module p_sbox4
   import p_pkg::*;
(
   input  logic [3:0] x,
   output logic [3:0] y
);

   assign y = sbox(x);

endmodule

// File: rtl/p_round.sv
// One registered PRESENT-80 round: addRoundKey, S-box layer, pLayer and
// one key-schedule step. Ports: clk, rst_n (async, active low), state[64],
// keys[80], round_counter[5] in; res[64], r_keys[80] registered out.
// Macro P_ROUND_VALID_EN adds in_valid/out_valid and a load enable.
module p_round
   import p_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [STATE_W-1:0] state,
   input  logic [KEY_W-1:0]   keys,
   input  logic [RC_W-1:0]    round_counter,
`ifdef P_ROUND_VALID_EN
   input  logic               in_valid,
   output logic               out_valid,
`endif
   output logic [STATE_W-1:0] res,
   output logic [KEY_W-1:0]   r_keys
);

   logic [STATE_W-1:0] t;
   logic [STATE_W-1:0] s_out;
   logic [STATE_W-1:0] res_d, res_q;
   logic [KEY_W-1:0]   k_rot;
   logic [3:0]         k_top;
   logic [KEY_W-1:0]   key_d, key_q;
   logic               load;

   assign t = state ^ keys[KEY_W-1:16];

   for (genvar n = 0; n < 16; n++) begin : g_sbox
      p_sbox4 u_sbox (
         .x (t[4*n+3:4*n]),
         .y (s_out[4*n+3:4*n])
      );
   end

   assign res_d = player(s_out);

   assign k_rot = {keys[18:0], keys[79:19]};

   p_sbox4 u_ksbox (
      .x (k_rot[79:76]),
      .y (k_top)
   );

   assign key_d = {k_top,
                   k_rot[75:20],
                   k_rot[19:15] ^ round_counter,
                   k_rot[14:0]};

`ifdef P_ROUND_VALID_EN
   logic ov_q;

   assign load = in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_q <= 1'b0;
      end else begin
         ov_q <= in_valid;
      end
   end

   assign out_valid = ov_q;
`else
   assign load = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         key_q <= '0;
      end else if (load) begin
         res_q <= res_d;
         key_q <= key_d;
      end
   end

   assign res    = res_q;
   assign r_keys = key_q;

endmodule

// File: tb/tb_p_round.sv
// Self-checking bench for p_round: per-cycle model comparison plus
// directed single-round and full-cipher known-answer vectors.
module tb_p_round;

   logic        clk;
   logic        rst_n;
   logic [63:0] state;
   logic [79:0] keys;
   logic [4:0]  round_counter;
   logic [63:0] res;
   logic [79:0] r_keys;
   logic        in_valid;
`ifdef P_ROUND_VALID_EN
   logic        out_valid;
`endif

   int checks;
   int failures;

   p_round dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .state         (state),
      .keys          (keys),
      .round_counter (round_counter),
`ifdef P_ROUND_VALID_EN
      .in_valid      (in_valid),
      .out_valid     (out_valid),
`endif
      .res           (res),
      .r_keys        (r_keys)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   function automatic logic [3:0] m_sb(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;
         4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;
         4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;
         4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;
         4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] m_slayer(input logic [63:0] x);
      logic [63:0] y;
      for (int n = 0; n < 16; n++) y[4*n +: 4] = m_sb(x[4*n +: 4]);
      return y;
   endfunction

   function automatic logic [63:0] m_perm(input logic [63:0] x);
      logic [63:0] y;
      int p;
      y = '0;
      for (int j = 0; j < 64; j++) begin
         p = (j == 63) ? 63 : (16 * j) % 63;
         y[p] = x[j];
      end
      return y;
   endfunction

   function automatic logic [63:0] m_res(input logic [63:0] s,
                                         input logic [79:0] k);
      return m_perm(m_slayer(s ^ k[79:16]));
   endfunction

   function automatic logic [79:0] m_key(input logic [79:0] k,
                                         input logic [4:0] rc);
      logic [79:0] r;
      r = (k << 61) | (k >> 19);
      r[79:76] = m_sb(r[79:76]);
      r[19:15] = r[19:15] ^ rc;
      return r;
   endfunction

   function automatic logic [63:0] m_cipher(input logic [63:0] pt,
                                            input logic [79:0] key);
      logic [63:0] s;
      logic [79:0] k;
      s = pt;
      k = key;
      for (int i = 1; i <= 31; i++) begin
         s = m_res(s, k);
         k = m_key(k, 5'(i));
      end
      return s ^ k[79:16];
   endfunction

   task automatic chk(input string nm, input logic [79:0] act,
                      input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Expected outputs, advanced from the inputs present at each edge.
   logic [63:0] exp_res;
   logic [79:0] exp_key;
   logic        exp_ov;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_res = '0;
         exp_key = '0;
         exp_ov  = 1'b0;
      end else begin
         exp_ov = in_valid;
         if (in_valid) begin
            exp_res = m_res(state, keys);
            exp_key = m_key(keys, round_counter);
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_res", 80'(res), 80'(exp_res));
      chk("cyc_key", r_keys, exp_key);
`ifdef P_ROUND_VALID_EN
      chk("cyc_ov", 80'(out_valid), 80'(exp_ov));
`endif
   end

   task automatic run_cipher(input logic [63:0] pt, input logic [79:0] key,
                             input logic [63:0] kat, input string nm);
      logic [63:0] s;
      logic [79:0] k;
      s = pt;
      k = key;
      @(negedge clk);
      for (int i = 1; i <= 31; i++) begin
         state = s;
         keys = k;
         round_counter = 5'(i);
         @(negedge clk);
         s = res;
         k = r_keys;
      end
      chk({nm, "_kat"}, 80'(s ^ k[79:16]), 80'(kat));
      chk({nm, "_model"}, 80'(m_cipher(pt, key)), 80'(kat));
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      state = '0;
      keys = '0;
      round_counter = '0;
      in_valid = 1'b1;

      // model pins
      chk("pin_slayer", 80'(m_slayer(64'h0123456789ABCDEF)),
          80'(64'hC56B90AD3EF84712));
      chk("pin_perm", 80'(m_perm(64'h0000_0000_0000_0002)),
          80'(64'h0000_0000_0001_0000));

      #2;
      chk("rst_res", 80'(res), 80'h0);
      chk("rst_key", r_keys, 80'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // single round, all zero
      state = '0;
      keys = '0;
      round_counter = 5'd1;
      @(negedge clk);
      chk("zero_res", 80'(res), 80'(64'hFFFFFFFF00000000));
      chk("zero_key", r_keys, 80'hC0000000000000008000);

      // S-box / pLayer
      state = 64'h0123456789ABCDEF;
      keys = '0;
      round_counter = 5'd0;
      @(negedge clk);
      chk("sp_res", 80'(res), 80'(m_perm(64'hC56B90AD3EF84712)));
      chk("sp_key", r_keys, 80'hC000_0000_0000_0000_0000);

      // asynchronous reset mid-cycle
      state = 64'hDEADBEEF_12345678;
      keys = 80'h1234_5678_9ABC_DEF0_1111;
      round_counter = 5'd7;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_res", 80'(res), 80'h0);
      chk("arst_key", r_keys, 80'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("hold_res", 80'(res), 80'h0);
      chk("hold_key", r_keys, 80'h0);

      run_cipher(64'h0, 80'h0, 64'h5579C1387B228445, "ct00");
      run_cipher(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, "ct0F");
      run_cipher({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, "ctF0");
      run_cipher({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, "ctFF");

`ifdef P_ROUND_VALID_EN
      state = 64'h0;
      keys = 80'h0;
      round_counter = 5'd1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         state = 64'h1111_0000_2222_0000 * 64'(i + 1);
         keys = 80'h5555_AAAA * 80'(i + 3);
         round_counter = 5'(i + 9);
         @(negedge clk);
         chk("vhold_res", 80'(res), 80'(64'hFFFFFFFF00000000));
         chk("vhold_key", r_keys, 80'hC0000000000000008000);
         chk("vhold_ov", 80'(out_valid), 80'h0);
      end
      in_valid = 1'b1;
      state = 64'h0123456789ABCDEF;
      keys = '0;
      round_counter = 5'd0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("vpulse_ov", 80'(out_valid), 80'h1);
      chk("vpulse_res", 80'(res), 80'(m_perm(64'hC56B90AD3EF84712)));
      @(negedge clk);
      chk("vpulse_ov_off", 80'(out_valid), 80'h0);
      in_valid = 1'b1;
`endif

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
